// File: rtl/fifo_ctrl_if.sv
// Request and register-file control bundle between the FIFO control stage and its neighbours.
// Latency: none, this is a plain signal bundle.
// Backpressure: none; a refused request is reported only through state.
interface fifo_ctrl_if;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] state;
  logic [3:0] data_count;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr;
  logic       we;
  logic       re;

  // Requester side: drives the requests and observes the control outputs.
  modport master (
    output wr_en, rd_en,
    input  state, data_count, wr_addr, rd_addr, we, re
  );

  // Control stage side.
  modport slave (
    input  wr_en, rd_en,
    output state, data_count, wr_addr, rd_addr, we, re
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Sequential control stage of an 8-entry FIFO: state, occupancy and head/tail pointers.
// Latency: we/re are combinational in the request cycle; state/data_count appear one cycle later.
// Backpressure: none; a write when full or a read when empty is refused and flagged in state.
module fifo_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  fifo_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    WRITE  = 3'b001,
    READ   = 3'b010,
    NO_OP  = 3'b011,
    WR_ERR = 3'b101,
    RD_ERR = 3'b110
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic       we_d;
  logic       re_d;

  // Decode the request against current occupancy. The next state depends only
  // on inputs, so an illegal code in state_q never persists. Simultaneous
  // write and read requests are ignored rather than executed.
  always_comb begin
    state_d  = NO_OP;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    if (bus.wr_en && !bus.rd_en) begin
      if (count_q != 4'd8) begin
        state_d  = WRITE;
        count_d  = count_q + 4'd1;
        wr_ptr_d = wr_ptr_q + 3'd1;
        we_d     = 1'b1;
      end else begin
        state_d  = WR_ERR;
      end
    end else if (bus.rd_en && !bus.wr_en) begin
      if (count_q != 4'd0) begin
        state_d  = READ;
        count_d  = count_q - 4'd1;
        rd_ptr_d = rd_ptr_q + 3'd1;
        re_d     = 1'b1;
      end else begin
        state_d  = RD_ERR;
      end
    end
  end

  // Register state, occupancy and pointers; reset discards all occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= INIT;
      count_q  <= 4'd0;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Strobes are suppressed for the whole time reset is held, so the register
  // file never commits in a cycle whose pointer update is being discarded.
  assign bus.we         = we_d & reset_n;
  assign bus.re         = re_d & reset_n;
  assign bus.state      = state_q;
  assign bus.data_count = count_q;
  assign bus.wr_addr    = wr_ptr_q;
  assign bus.rd_addr    = rd_ptr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: directed sequences plus random traffic against a reference model.
// Latency: expectations queued in the request cycle, popped one edge later.
// Backpressure: not applicable.
module tb_fifo_ctrl;

  localparam logic [2:0] S_INIT   = 3'b000;
  localparam logic [2:0] S_WRITE  = 3'b001;
  localparam logic [2:0] S_READ   = 3'b010;
  localparam logic [2:0] S_NO_OP  = 3'b011;
  localparam logic [2:0] S_WR_ERR = 3'b101;
  localparam logic [2:0] S_RD_ERR = 3'b110;

  typedef struct {
    logic [2:0] st;
    logic [3:0] cnt;
    logic [2:0] wa;
    logic [2:0] ra;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  exp_t sb[$];

  // Reference model of the registered state.
  logic [2:0] m_st;
  logic [3:0] m_cnt;
  logic [2:0] m_wa;
  logic [2:0] m_ra;
  bit         m_valid;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive requests, check combinational strobes and
  // pre-increment addresses, queue the expected post-edge state, then
  // pop and compare after the edge.
  task automatic cycle(input logic rn, input logic w, input logic r);
    exp_t       e;
    logic       ew;
    logic       er;
    logic [2:0] dw;
    logic [2:0] dr;
    logic [3:0] dc;
    bit         inv_ok;

    @(negedge clk);
    reset_n   = rn;
    bus.wr_en = w;
    bus.rd_en = r;
    #1;
    ew = rn && w && !r && (m_cnt != 4'd8);
    er = rn && r && !w && (m_cnt != 4'd0);
    chk("we", {31'd0, bus.we}, {31'd0, ew});
    chk("re", {31'd0, bus.re}, {31'd0, er});
    if (m_valid) begin
      chk("wr_addr_pre", {29'd0, bus.wr_addr}, {29'd0, m_wa});
      chk("rd_addr_pre", {29'd0, bus.rd_addr}, {29'd0, m_ra});
    end

    if (!rn) begin
      m_st = S_INIT; m_cnt = 4'd0; m_wa = 3'd0; m_ra = 3'd0;
      m_valid = 1'b1;
    end else if (w && !r) begin
      if (m_cnt < 4'd8) begin
        m_st = S_WRITE; m_cnt = m_cnt + 4'd1; m_wa = m_wa + 3'd1;
      end else begin
        m_st = S_WR_ERR;
      end
    end else if (r && !w) begin
      if (m_cnt > 4'd0) begin
        m_st = S_READ; m_cnt = m_cnt - 4'd1; m_ra = m_ra + 3'd1;
      end else begin
        m_st = S_RD_ERR;
      end
    end else begin
      m_st = S_NO_OP;
    end
    e.st = m_st; e.cnt = m_cnt; e.wa = m_wa; e.ra = m_ra;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state", {29'd0, bus.state}, {29'd0, e.st});
    chk("data_count", {28'd0, bus.data_count}, {28'd0, e.cnt});
    chk("wr_addr", {29'd0, bus.wr_addr}, {29'd0, e.wa});
    chk("rd_addr", {29'd0, bus.rd_addr}, {29'd0, e.ra});

    // Occupancy must agree with pointer distance; equal pointers mean 0 or 8.
    dw = bus.wr_addr;
    dr = bus.rd_addr;
    dc = bus.data_count;
    inv_ok = (dc <= 4'd8) &&
             ((dc == {1'b0, 3'(dw - dr)}) || (dc == 4'd8 && dw == dr));
    chk("invariant", {31'd0, inv_ok}, 32'd1);
  endtask

  initial begin
    int op;
    checks    = 0;
    errors    = 0;
    m_st      = S_INIT;
    m_cnt     = 4'd0;
    m_wa      = 3'd0;
    m_ra      = 3'd0;
    m_valid   = 1'b0;
    reset_n   = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    // Reset for two edges, then idle release.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // Eight writes from empty, then an overflow attempt and a read.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);

    // Reset, read on empty, then one write.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);

    // Grow to 3, then two cycles of simultaneous requests.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);

    // Fill to 5, reset with a write pending, then random traffic.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 3);
      cycle(1'b1, op[0], op[1]);
    end
    // Drain past empty and refill past full to cover both error states again.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
